// File: rtl/vga_box_renderer.sv
// Pixel-colour stage for 640x480 VGA: draws a solid square that bounces diagonally
// over a fixed background, moving one step per frame during vertical blank.
module vga_box_renderer #(
    parameter int           H_ACTIVE  = 640,
    parameter int           V_ACTIVE  = 480,
    parameter int           BOX_SIZE  = 32,
    parameter int           STEP      = 2,
    parameter logic [7:0]   BOX_COLOR = 8'hE0,
    parameter logic [7:0]   BG_COLOR  = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        blank,
    input  logic        run,
    output logic [2:0]  R,
    output logic [2:0]  G,
    output logic [1:0]  B,
    output logic        frame_tick
);

    localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] STEP_W   = 12'(STEP);
    localparam logic [11:0] BOX_W    = 12'(BOX_SIZE);
    localparam logic [10:0] V_TICK   = 11'(V_ACTIVE);

    typedef enum logic {RIGHT, LEFT} x_dir_t;
    typedef enum logic {DOWN,  UP}   y_dir_t;

    logic [11:0] x_pos, y_pos, x_pos_next, y_pos_next;
    x_dir_t      x_dir, x_dir_next;
    y_dir_t      y_dir, y_dir_next;
    logic [10:0] vcount_q;
    logic        tick;
    logic        in_box;
    logic [11:0] h_w, v_w;

    // First cycle of line V_ACTIVE; vcount_q suppresses repeats while the line persists.
    assign tick = (vcount == V_TICK) && (vcount_q != V_TICK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pos      <= '0;
            y_pos      <= '0;
            x_dir      <= RIGHT;
            y_dir      <= DOWN;
            vcount_q   <= '0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            x_pos      <= x_pos_next;
            y_pos      <= y_pos_next;
            x_dir      <= x_dir_next;
            y_dir      <= y_dir_next;
            vcount_q   <= vcount;
            frame_tick <= tick;
        end
    end

    always_comb begin
        // NOTE: hold values assigned first so no path through this block infers a latch.
        x_pos_next = x_pos;
        y_pos_next = y_pos;
        x_dir_next = x_dir;
        y_dir_next = y_dir;
        if (tick && run) begin
            unique case (x_dir)
                RIGHT: if (x_pos + STEP_W >= X_MAX) begin
                           x_pos_next = X_MAX;
                           x_dir_next = LEFT;
                       end else begin
                           x_pos_next = x_pos + STEP_W;
                       end
                LEFT:  if (x_pos <= STEP_W) begin
                           x_pos_next = '0;
                           x_dir_next = RIGHT;
                       end else begin
                           x_pos_next = x_pos - STEP_W;
                       end
            endcase
            unique case (y_dir)
                DOWN:  if (y_pos + STEP_W >= Y_MAX) begin
                           y_pos_next = Y_MAX;
                           y_dir_next = UP;
                       end else begin
                           y_pos_next = y_pos + STEP_W;
                       end
                UP:    if (y_pos <= STEP_W) begin
                           y_pos_next = '0;
                           y_dir_next = DOWN;
                       end else begin
                           y_pos_next = y_pos - STEP_W;
                       end
            endcase
        end
    end

    assign h_w    = {1'b0, hcount};
    assign v_w    = {1'b0, vcount};
    assign in_box = (h_w >= x_pos) && (h_w < x_pos + BOX_W) &&
                    (v_w >= y_pos) && (v_w < y_pos + BOX_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {R, G, B} <= 8'h00;
        end else if (blank) begin
            {R, G, B} <= 8'h00;
        end else if (in_box) begin
            {R, G, B} <= BOX_COLOR;
        end else begin
            {R, G, B} <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: reset, tick, bounce, blank/run and mid-frame reset,
// plus a STEP=3 instance for the left-edge clamp.
module tb_vga_box_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount, vcount;
    logic        blank, run, run3;
    logic [2:0]  R, G, R3, G3;
    logic [1:0]  B, B3;
    logic        frame_tick, frame_tick3;
    int          checks = 0;
    int          passed = 0;
    int          tick_cnt;

    always #20 clk = ~clk;

    vga_box_renderer dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
        .run(run), .R(R), .G(G), .B(B), .frame_tick(frame_tick)
    );

    vga_box_renderer #(.STEP(3)) dut3 (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
        .run(run3), .R(R3), .G(G3), .B(B3), .frame_tick(frame_tick3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic b);
        @(negedge clk);
        hcount = h;
        vcount = v;
        blank  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        pix(11'd0, 11'd479, 1'b1);
        pix(11'd0, 11'd480, 1'b1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; run3 = 1'b0;
        hcount = 11'd0; vcount = 11'd0; blank = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rgb_in_reset", {R, G, B}, 8'h00);
        check("tick_in_reset", frame_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pix(11'd0, 11'd0, 1'b0);
        check("rgb_0_0", {R, G, B}, 8'hE0);
        pix(11'd32, 11'd0, 1'b0);
        check("rgb_32_0", {R, G, B}, 8'h03);
        pix(11'd31, 11'd31, 1'b0);
        check("rgb_31_31", {R, G, B}, 8'hE0);
        pix(11'd0, 11'd32, 1'b0);
        check("rgb_0_32", {R, G, B}, 8'h03);
        check("no_tick_after_reset", frame_tick, 1'b0);

        // Motion and tick
        run = 1'b1;
        pix(11'd0, 11'd479, 1'b1);
        check("tick_before_480", frame_tick, 1'b0);
        pix(11'd0, 11'd480, 1'b1);
        check("tick_pulse", frame_tick, 1'b1);
        tick_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            pix(11'd0, 11'd480, 1'b1);
            if (frame_tick) tick_cnt++;
        end
        check("no_second_tick", tick_cnt, 0);
        pix(11'd1, 11'd1, 1'b0);
        check("rgb_1_1_after_tick", {R, G, B}, 8'h03);
        pix(11'd2, 11'd2, 1'b0);
        check("rgb_2_2_after_tick", {R, G, B}, 8'hE0);
        pix(11'd33, 11'd33, 1'b0);
        check("rgb_33_33_after_tick", {R, G, B}, 8'hE0);
        pix(11'd34, 11'd2, 1'b0);
        check("rgb_34_2_after_tick", {R, G, B}, 8'h03);

        // Right/bottom bounce (one tick already done)
        for (int i = 2; i <= 224; i++) do_tick();
        check("y_at_224", dut.y_pos, 12'd448);
        check("x_at_224", dut.x_pos, 12'd448);
        do_tick();
        check("y_at_225", dut.y_pos, 12'd446);
        for (int i = 226; i <= 304; i++) do_tick();
        check("x_at_304", dut.x_pos, 12'd608);
        check("y_at_304", dut.y_pos, 12'd288);
        pix(11'd639, 11'd288, 1'b0);
        check("rgb_639_288", {R, G, B}, 8'hE0);
        pix(11'd607, 11'd288, 1'b0);
        check("rgb_607_288", {R, G, B}, 8'h03);
        do_tick();
        check("x_at_305", dut.x_pos, 12'd606);

        // Blank and run
        pix(11'd610, 11'd290, 1'b1);
        check("rgb_blank_in_box", {R, G, B}, 8'h00);
        pix(11'd610, 11'd290, 1'b0);
        check("rgb_visible_in_box", {R, G, B}, 8'hE0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_tick();
            check("tick_with_run0", frame_tick, 1'b1);
        end
        check("x_hold_run0", dut.x_pos, 12'd606);
        check("y_hold_run0", dut.y_pos, 12'd286);

        // Mid-frame reset after 10 ticks
        run = 1'b1;
        for (int i = 0; i < 10; i++) do_tick();
        check("x_after_10", dut.x_pos, 12'd586);
        pix(11'd300, 11'd200, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rgb_async_reset", {R, G, B}, 8'h00);
        check("x_async_reset", dut.x_pos, 12'd0);
        check("y_async_reset", dut.y_pos, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        do_tick();
        check("x_after_reset_tick", dut.x_pos, 12'd2);
        check("y_after_reset_tick", dut.y_pos, 12'd2);

        // Left bounce with STEP=3
        run  = 1'b0;
        run3 = 1'b1;
        for (int i = 1; i <= 405; i++) begin
            do_tick();
            if (i == 203) check("s3_x_right_clamp", dut3.x_pos, 12'd608);
        end
        check("s3_x_at_2", dut3.x_pos, 12'd2);
        do_tick();
        check("s3_x_left_clamp", dut3.x_pos, 12'd0);
        do_tick();
        check("s3_x_restart", dut3.x_pos, 12'd3);
        check("main_dut_held", dut.x_pos, 12'd2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_box_renderer.md
# vga_box_renderer

Pixel-colour stage that sits directly downstream of the 640x480@60 VGA timing controller. It consumes the controller's horizontal count, vertical count and blank signal, and drives the 8-bit R/G/B bus (3/3/2) to the DAC pins. It draws a solid square that moves diagonally once per frame and bounces off the visible-area edges, over a fixed background colour. All outputs are registered, and motion updates only during vertical blanking, so no tearing occurs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_SIZE, 32, square edge length in pixels (1..V_ACTIVE)
- STEP, 2, pixels moved per frame on each axis (1..BOX_SIZE)
- BOX_COLOR, 8'hE0, {R[2:0],G[2:0],B[1:0]} inside the square
- BG_COLOR, 8'h03, {R,G,B} for visible pixels outside the square

- clk  in  1  pixel clock (25 MHz, same clock as the timing controller)
- rst  in  1  asynchronous, active-high reset
- hcount  in  11  current pixel column from the timing controller
- vcount  in  11  current line from the timing controller
- blank  in  1  high outside the visible area
- run  in  1  motion enable, sampled at the frame tick
- R  out  3  red, registered
- G  out  3  green, registered
- B  out  2  blue, registered
- frame_tick  out  1  one-cycle pulse marking the start of vertical blank, registered

## Operation
- Reset (asynchronous): x_pos=0, y_pos=0, dx=RIGHT, dy=DOWN, R/G/B=0, frame_tick=0, vcount_q=0.
- **Frame tick**
  - Register vcount_q <= vcount every cycle.
  - Internal tick = (vcount==V_ACTIVE) && (vcount_q!=V_ACTIVE). It fires exactly once per frame, on the first cycle of line V_ACTIVE.
- **Motion**
  - Motion occurs only on the internal tick, and only if run=1. With run=0, x_pos, y_pos, dx and dy hold.
  - Per-axis two-state FSM, X axis (Y is identical, using y_pos, V_ACTIVE and UP/DOWN):
    - RIGHT: if x_pos+STEP >= H_ACTIVE-BOX_SIZE, set x_pos=H_ACTIVE-BOX_SIZE and go to LEFT. Otherwise x_pos += STEP.
    - LEFT: if x_pos <= STEP, set x_pos=0 and go to RIGHT. Otherwise x_pos -= STEP.
  - Sums are computed 12 bits wide; there is no wrap-around. Positions always stay in [0, H_ACTIVE-BOX_SIZE] and [0, V_ACTIVE-BOX_SIZE].
  - Both axes update on the same tick. A simultaneous corner hit flips both directions.
- **Pixel colour** (evaluated every cycle from the current inputs)
  - in_box = (hcount >= x_pos) && (hcount < x_pos+BOX_SIZE) && (vcount >= y_pos) && (vcount < y_pos+BOX_SIZE). Comparisons are unsigned, 12 bits wide.
  - blank=1: {R,G,B} <= 8'h00.
  - blank=0 and in_box: {R,G,B} <= BOX_COLOR.
  - Otherwise: {R,G,B} <= BG_COLOR.
- The box edges are inclusive on the left and top, and exclusive on the right and bottom.
- Position updates happen while blank=1, so every visible frame renders a single consistent box position.

## Timing
- Pixel latency is 1 cycle: R/G/B at edge n+1 reflect hcount/vcount/blank sampled at edge n. The integrator delays HS/VS by one cycle to align with R/G/B.
- frame_tick is high for the one cycle after the edge at which the internal tick is detected.
- New x_pos/y_pos values become visible starting with the first visible pixel of the next frame.
- Reset asserted mid-frame:
  - Outputs go to 0 immediately (asynchronous).
  - After release, the first tick occurs at the next line V_ACTIVE. vcount_q=0 prevents a spurious tick unless vcount==V_ACTIVE on the first sampled cycle, in which case one tick is allowed.
- run changing mid-frame has effect only at the next tick.

## Test plan
- **Reset state:** assert rst, drive blank=0, hcount=0, vcount=0 → R/G/B=0 while rst is high. One cycle after release, {R,G,B}=8'hE0. At (32,0), 8'h03. At (31,31), 8'hE0. At (0,32), 8'h03.
- **Motion and tick:** run=1, step vcount 479→480 → frame_tick pulses exactly one cycle. The box now spans columns 2..33 and rows 2..33 (pixel (1,1)=8'h03, (2,2)=8'hE0). Holding vcount=480 for 100 cycles produces no second tick.
- **Right/bottom bounce:** run 224 ticks → y_pos=448 with dy=UP; the next tick gives y_pos=446. Continue to 304 ticks → x_pos=608 with dx=LEFT; the next tick gives x_pos=606. Pixel (639,y_pos)=8'hE0 while x_pos=608.
- **Left bounce and clamp:** with STEP=3, from x_pos=2 with dx=LEFT, tick → x_pos=0 and dx=RIGHT; next tick → x_pos=3.
- **Blank and run:** blank=1 with hcount/vcount inside the box → {R,G,B}=8'h00. With run=0 across 5 ticks, the position is unchanged and frame_tick still pulses each frame.
- **Mid-frame reset:** assert rst at hcount=300, vcount=200 after 10 ticks → position returns to 0,0 and RGB=0 within the same cycle. The next tick after release gives x_pos=2.
